// File: rtl/kernal_pos_traverse_gen_if.sv
// Point stream between the kernel walker and the address generators.
// Master drives points; slave returns m_pt_ready.
interface kernal_pos_traverse_gen_if #(
    parameter int COORD_WIDTH    = 8,
    parameter int PASS_CNT_WIDTH = 16
);
    logic                      m_pt_valid;
    logic                      m_pt_ready;
    logic [COORD_WIDTH-1:0]    kernal_logic_x;
    logic [COORD_WIDTH-1:0]    kernal_logic_y;
    logic [COORD_WIDTH-1:0]    kernal_phy_x;
    logic [COORD_WIDTH-1:0]    kernal_phy_y;
    logic                      kernal_pt_on_grid;
    logic                      kernal_last_in_row;
    logic                      kernal_last_in_kernal;
    logic [PASS_CNT_WIDTH-1:0] kernal_pass_cnt;

    modport master (
        output m_pt_valid,
        output kernal_logic_x,
        output kernal_logic_y,
        output kernal_phy_x,
        output kernal_phy_y,
        output kernal_pt_on_grid,
        output kernal_last_in_row,
        output kernal_last_in_kernal,
        output kernal_pass_cnt,
        input  m_pt_ready
    );

    modport slave (
        input  m_pt_valid,
        input  kernal_logic_x,
        input  kernal_logic_y,
        input  kernal_phy_x,
        input  kernal_phy_y,
        input  kernal_pt_on_grid,
        input  kernal_last_in_row,
        input  kernal_last_in_kernal,
        input  kernal_pass_cnt,
        output m_pt_ready
    );
endinterface

// File: rtl/kernal_pos_traverse_gen.sv
// Raster walker over the dilated kernel window with hole phase counters.
// KERNAL_POS_FLIP_EN adds kernal_flip_en for 180-degree rotated phy taps.
module kernal_pos_traverse_gen #(
    parameter int COORD_WIDTH    = 8,
    parameter int KSIZE_WIDTH    = 4,
    parameter int DLT_WIDTH      = 4,
    parameter int PASS_CNT_WIDTH = 16,
    parameter int SIM_DELAY      = 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   aclken,
    input  logic [DLT_WIDTH-1:0]   kernal_dilation_hzt_n,
    input  logic [DLT_WIDTH-1:0]   kernal_dilation_vtc_n,
    input  logic [KSIZE_WIDTH-1:0] kernal_w,
    input  logic [KSIZE_WIDTH-1:0] kernal_h,
    input  logic                   skip_holes,
    input  logic                   rst_cvt,
`ifdef KERNAL_POS_FLIP_EN
    input  logic                   kernal_flip_en,
`endif
    kernal_pos_traverse_gen_if.master m_pt
);
    logic [COORD_WIDTH-1:0]    lx, ly, px, py;
    logic [COORD_WIDTH-1:0]    lx_n, ly_n, px_n, py_n;
    logic [COORD_WIDTH-1:0]    xstep, ystep, lxm, lym;
    logic [DLT_WIDTH-1:0]      hx, hy, hx_n, hy_n;
    logic [PASS_CNT_WIDTH-1:0] pcnt, pcnt_n;
    logic                      vld, adv, row_end, ker_end;

    // Behavioural-model delay only; registers here update at the edge.
    if (SIM_DELAY < 0) begin : g_sim_delay
    end

    assign xstep   = COORD_WIDTH'(kernal_dilation_hzt_n) + COORD_WIDTH'(1);
    assign ystep   = COORD_WIDTH'(kernal_dilation_vtc_n) + COORD_WIDTH'(1);
    assign lxm     = COORD_WIDTH'(kernal_w) * xstep;
    assign lym     = COORD_WIDTH'(kernal_h) * ystep;
    assign row_end = (lx == lxm);
    assign ker_end = row_end && (ly == lym);
    assign adv     = vld && m_pt.m_pt_ready;

    always_comb begin
        lx_n   = lx;
        ly_n   = ly;
        px_n   = px;
        py_n   = py;
        hx_n   = hx;
        hy_n   = hy;
        pcnt_n = pcnt;
        if (rst_cvt) begin
            lx_n   = '0;
            ly_n   = '0;
            px_n   = '0;
            py_n   = '0;
            hx_n   = '0;
            hy_n   = '0;
            pcnt_n = '0;
        end else if (adv) begin
            if (!row_end) begin
                if (skip_holes) begin
                    lx_n = lx + xstep;
                    px_n = px + COORD_WIDTH'(1);
                end else begin
                    lx_n = lx + COORD_WIDTH'(1);
                    if (hx == kernal_dilation_hzt_n) begin
                        hx_n = '0;
                        px_n = px + COORD_WIDTH'(1);
                    end else begin
                        hx_n = hx + DLT_WIDTH'(1);
                    end
                end
            end else begin
                lx_n = '0;
                px_n = '0;
                hx_n = '0;
                if (ker_end) begin
                    ly_n   = '0;
                    py_n   = '0;
                    hy_n   = '0;
                    pcnt_n = pcnt + PASS_CNT_WIDTH'(1);
                end else if (skip_holes) begin
                    ly_n = ly + ystep;
                    py_n = py + COORD_WIDTH'(1);
                end else begin
                    ly_n = ly + COORD_WIDTH'(1);
                    if (hy == kernal_dilation_vtc_n) begin
                        hy_n = '0;
                        py_n = py + COORD_WIDTH'(1);
                    end else begin
                        hy_n = hy + DLT_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lx   <= '0;
            ly   <= '0;
            px   <= '0;
            py   <= '0;
            hx   <= '0;
            hy   <= '0;
            pcnt <= '0;
            vld  <= 1'b0;
        end else if (aclken) begin
            lx   <= lx_n;
            ly   <= ly_n;
            px   <= px_n;
            py   <= py_n;
            hx   <= hx_n;
            hy   <= hy_n;
            pcnt <= pcnt_n;
            vld  <= !rst_cvt;
        end
    end

`ifdef KERNAL_POS_FLIP_EN
    logic [COORD_WIDTH-1:0] fpx, fpy;

    // Mirror from next-state so the flipped taps keep coordinate latency.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fpx <= '0;
            fpy <= '0;
        end else if (aclken) begin
            fpx <= kernal_flip_en ? COORD_WIDTH'(kernal_w) - px_n : px_n;
            fpy <= kernal_flip_en ? COORD_WIDTH'(kernal_h) - py_n : py_n;
        end
    end

    assign m_pt.kernal_phy_x = fpx;
    assign m_pt.kernal_phy_y = fpy;
`else
    assign m_pt.kernal_phy_x = px;
    assign m_pt.kernal_phy_y = py;
`endif

    assign m_pt.m_pt_valid            = vld;
    assign m_pt.kernal_logic_x        = lx;
    assign m_pt.kernal_logic_y        = ly;
    assign m_pt.kernal_pt_on_grid     = (hx == '0) && (hy == '0);
    assign m_pt.kernal_last_in_row    = row_end;
    assign m_pt.kernal_last_in_kernal = ker_end;
    assign m_pt.kernal_pass_cnt       = pcnt;
endmodule

// File: tb/tb_kernal_pos_traverse_gen.sv
// Bench for kernal_pos_traverse_gen: config table with a point scoreboard,
// plus backpressure, rst_cvt, 1x1 wrap and optional flip sequences.
module tb_kernal_pos_traverse_gen;
    localparam int CW = 8;
    localparam int KW = 4;
    localparam int DW = 4;
    localparam int PW = 6;

    typedef struct packed {
        logic [CW-1:0] lx;
        logic [CW-1:0] ly;
        logic [CW-1:0] px;
        logic [CW-1:0] py;
        logic          og;
        logic          lr;
        logic          lk;
        logic [PW-1:0] pc;
    } pt_t;

    typedef struct {
        int w;
        int h;
        int dh;
        int dv;
        bit skip;
        int npts;
    } vec_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          aclken = 1'b1;
    logic [DW-1:0] dh = '0;
    logic [DW-1:0] dv = '0;
    logic [KW-1:0] kw = '0;
    logic [KW-1:0] kh = '0;
    logic          skip = 1'b0;
    logic          rst_cvt = 1'b0;
    logic          flip = 1'b0;

    int checks = 0;
    int failures = 0;

    pt_t exp_q[$];
    vec_t tbl[7];

    always #5 aclk = ~aclk;

    kernal_pos_traverse_gen_if #(
        .COORD_WIDTH(CW),
        .PASS_CNT_WIDTH(PW)
    ) pt_if ();

    kernal_pos_traverse_gen #(
        .COORD_WIDTH(CW),
        .KSIZE_WIDTH(KW),
        .DLT_WIDTH(DW),
        .PASS_CNT_WIDTH(PW),
        .SIM_DELAY(1)
    ) u_dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .aclken(aclken),
        .kernal_dilation_hzt_n(dh),
        .kernal_dilation_vtc_n(dv),
        .kernal_w(kw),
        .kernal_h(kh),
        .skip_holes(skip),
        .rst_cvt(rst_cvt),
`ifdef KERNAL_POS_FLIP_EN
        .kernal_flip_en(flip),
`endif
        .m_pt(pt_if.master)
    );

    function automatic pt_t exp_pt(int x, int y, int pc);
        pt_t e;
        int sx, sy, lxm, lym, qx, qy;
        sx  = int'(dh) + 1;
        sy  = int'(dv) + 1;
        lxm = int'(kw) * sx;
        lym = int'(kh) * sy;
        qx  = x / sx;
        qy  = y / sy;
        if (flip) begin
            qx = int'(kw) - qx;
            qy = int'(kh) - qy;
        end
        e.lx = x[CW-1:0];
        e.ly = y[CW-1:0];
        e.px = qx[CW-1:0];
        e.py = qy[CW-1:0];
        e.og = (x % sx == 0) && (y % sy == 0);
        e.lr = (x == lxm);
        e.lk = (x == lxm) && (y == lym);
        e.pc = pc[PW-1:0];
        return e;
    endfunction

    function automatic pt_t cur();
        pt_t c;
        c.lx = pt_if.kernal_logic_x;
        c.ly = pt_if.kernal_logic_y;
        c.px = pt_if.kernal_phy_x;
        c.py = pt_if.kernal_phy_y;
        c.og = pt_if.kernal_pt_on_grid;
        c.lr = pt_if.kernal_last_in_row;
        c.lk = pt_if.kernal_last_in_kernal;
        c.pc = pt_if.kernal_pass_cnt;
        return c;
    endfunction

    task automatic check_pt(input string name, input pt_t e);
        pt_t c;
        c = cur();
        checks++;
        if (c !== e) begin
            failures++;
            $display("FAIL %s: got l=(%0d,%0d) p=(%0d,%0d) g/r/k=%b%b%b pc=%0d want l=(%0d,%0d) p=(%0d,%0d) g/r/k=%b%b%b pc=%0d",
                     name, c.lx, c.ly, c.px, c.py, c.og, c.lr, c.lk, c.pc,
                     e.lx, e.ly, e.px, e.py, e.og, e.lr, e.lk, e.pc);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic do_rst_cvt();
        @(negedge aclk);
        pt_if.m_pt_ready = 1'b0;
        rst_cvt = 1'b1;
        @(negedge aclk);
        rst_cvt = 1'b0;
        check_val("rst_cvt_valid_drop", int'(pt_if.m_pt_valid), 0);
        check_pt("rst_cvt_origin", exp_pt(0, 0, 0));
        @(negedge aclk);
        check_val("rst_cvt_valid_back", int'(pt_if.m_pt_valid), 1);
    endtask

    task automatic run_vec(input vec_t v);
        int xs, ys, n, cyc;
        bit seen, r;
        pt_t e;
        kw   = KW'(v.w);
        kh   = KW'(v.h);
        dh   = DW'(v.dh);
        dv   = DW'(v.dv);
        skip = v.skip;
        do_rst_cvt();
        xs = v.skip ? v.dh + 1 : 1;
        ys = v.skip ? v.dv + 1 : 1;
        for (int y = 0; y <= v.h * (v.dv + 1); y += ys)
            for (int x = 0; x <= v.w * (v.dh + 1); x += xs)
                exp_q.push_back(exp_pt(x, y, 0));
        exp_q.push_back(exp_pt(0, 0, 1));
        n    = 0;
        cyc  = 0;
        seen = 1'b0;
        while (exp_q.size() > 0) begin
            if (cyc > 4000) begin
                checks++;
                failures++;
                $display("FAIL stream_timeout: %0d points left", exp_q.size());
                exp_q.delete();
                break;
            end
            r = ($urandom_range(0, 2) != 0);
            if (r && pt_if.m_pt_valid) begin
                e = exp_q.pop_front();
                n++;
                check_pt("stream", e);
                if (e.lk && !seen) begin
                    seen = 1'b1;
                    check_val("points_per_pass", n, v.npts);
                end
            end else if (pt_if.m_pt_valid) begin
                check_pt("stream_hold", exp_q[0]);
            end
            pt_if.m_pt_ready = r;
            @(negedge aclk);
            cyc++;
        end
        pt_if.m_pt_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{w: 3, h: 3, dh: 1, dv: 1, skip: 1'b0, npts: 49};
        tbl[1] = '{w: 3, h: 3, dh: 1, dv: 1, skip: 1'b1, npts: 16};
        tbl[2] = '{w: 2, h: 1, dh: 2, dv: 0, skip: 1'b0, npts: 14};
        tbl[3] = '{w: 0, h: 0, dh: 3, dv: 3, skip: 1'b0, npts: 1};
        tbl[4] = '{w: 1, h: 2, dh: 0, dv: 1, skip: 1'b1, npts: 6};
        tbl[5] = '{w: 4, h: 0, dh: 0, dv: 0, skip: 1'b0, npts: 5};
        tbl[6] = '{w: 2, h: 2, dh: 1, dv: 2, skip: 1'b0, npts: 35};

        pt_if.m_pt_ready = 1'b0;
        kw = 4'd3;
        kh = 4'd3;
        dh = 4'd1;
        dv = 4'd1;
        @(negedge aclk);
        @(negedge aclk);
        check_val("reset_valid", int'(pt_if.m_pt_valid), 0);
        check_pt("reset_point", exp_pt(0, 0, 0));
        aresetn = 1'b1;
        @(negedge aclk);
        check_val("first_valid", int'(pt_if.m_pt_valid), 1);

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // backpressure at logic_y=2, logic_x=3 on the 4x4 dilated kernel
        kw = 4'd3;
        kh = 4'd3;
        dh = 4'd1;
        dv = 4'd1;
        skip = 1'b0;
        do_rst_cvt();
        pt_if.m_pt_ready = 1'b1;
        repeat (17) @(negedge aclk);
        pt_if.m_pt_ready = 1'b0;
        check_pt("bp_enter", exp_pt(3, 2, 0));
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check_pt("bp_frozen", exp_pt(3, 2, 0));
        end
        pt_if.m_pt_ready = 1'b1;
        @(negedge aclk);
        pt_if.m_pt_ready = 1'b0;
        check_pt("bp_resume", exp_pt(4, 2, 0));

        // rst_cvt together with a handshake at (4,5) in pass 3
        do_rst_cvt();
        pt_if.m_pt_ready = 1'b1;
        repeat (3 * 49 + 39) @(negedge aclk);
        pt_if.m_pt_ready = 1'b0;
        check_pt("pre_rst_cvt", exp_pt(4, 5, 3));
        rst_cvt = 1'b1;
        pt_if.m_pt_ready = 1'b1;
        @(negedge aclk);
        rst_cvt = 1'b0;
        pt_if.m_pt_ready = 1'b0;
        check_val("hs_rst_valid", int'(pt_if.m_pt_valid), 0);
        check_pt("hs_rst_point", exp_pt(0, 0, 0));
        @(negedge aclk);
        check_val("hs_rst_valid_back", int'(pt_if.m_pt_valid), 1);

        // 1x1 kernel: every handshake is a full pass, counter wraps
        kw = 4'd0;
        kh = 4'd0;
        dh = 4'd3;
        dv = 4'd3;
        do_rst_cvt();
        pt_if.m_pt_ready = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            @(negedge aclk);
            check_pt("one_by_one", exp_pt(0, 0, k));
        end
        aclken = 1'b0;
        repeat (3) @(negedge aclk);
        check_pt("clken_hold", exp_pt(0, 0, 70));
        aclken = 1'b1;
        pt_if.m_pt_ready = 1'b0;

`ifdef KERNAL_POS_FLIP_EN
        flip = 1'b1;
        kw = 4'd2;
        kh = 4'd2;
        dh = 4'd0;
        dv = 4'd0;
        do_rst_cvt();
        check_pt("flip_origin", exp_pt(0, 0, 0));
        pt_if.m_pt_ready = 1'b1;
        repeat (5) @(negedge aclk);
        pt_if.m_pt_ready = 1'b0;
        check_pt("flip_2_1", exp_pt(2, 1, 0));
        flip = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
